// File: rtl/hazard_unit_mc_if.sv
// rtl/hazard_unit_mc_if.sv - pipeline-side signal bundle between the pipeline and hazard_unit_mc
interface hazard_unit_mc_if #(
  parameter int REG_AW = 5
);
  logic [REG_AW-1:0] Rs1D, Rs2D, RdD;
  logic [REG_AW-1:0] Rs1E, Rs2E, RdE;
  logic [REG_AW-1:0] RdM, RdW;
  logic [1:0]        ResultSrcE;
  logic              RegWriteD, RegWriteM, RegWriteW;
  logic              McOpD, McOpE;
  logic              PCSrcE;
  logic              StallF, StallD, FlushD, FlushE;
  logic [1:0]        ForwardAE, ForwardBE;
  logic              mc_busy, mc_done;
  logic [REG_AW-1:0] mc_rd;

  // Pipeline side: presents stage indices/enables, consumes controls
  modport master (
    output Rs1D, Rs2D, RdD, Rs1E, Rs2E, RdE, RdM, RdW, ResultSrcE,
           RegWriteD, RegWriteM, RegWriteW, McOpD, McOpE, PCSrcE,
    input  StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE,
           mc_busy, mc_done, mc_rd
  );

  // Hazard unit side
  modport slave (
    input  Rs1D, Rs2D, RdD, Rs1E, Rs2E, RdE, RdM, RdW, ResultSrcE,
           RegWriteD, RegWriteM, RegWriteW, McOpD, McOpE, PCSrcE,
    output StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE,
           mc_busy, mc_done, mc_rd
  );
endinterface

// File: rtl/hazard_unit_mc.sv
// rtl/hazard_unit_mc.sv - hazard/forwarding unit with one multi-cycle unit scoreboard; HAZ_PERF_CNT_EN adds stall/flush counters
module hazard_unit_mc #(
  parameter int REG_AW = 5,
  parameter int MC_LAT = 8,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  hazard_unit_mc_if.slave  hz
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam logic [REG_AW-1:0] R0     = '0;
  localparam logic [7:0]        LAT_M1 = 8'(MC_LAT - 1);

  state_t            state, state_nx;
  logic [7:0]        cnt, cnt_nx;
  logic [REG_AW-1:0] mc_rd_q, mc_rd_nx;
  logic              busy, done;
  logic              lw, sb_raw, sb_waw, st, stall;

  // Forward priority: M stage, then W stage, then the MC result on its done cycle
  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs,
                                         input logic [REG_AW-1:0] rdm, input logic rwm,
                                         input logic [REG_AW-1:0] rdw, input logic rww,
                                         input logic dn, input logic [REG_AW-1:0] mrd);
    if (rs != R0 && rs == rdm && rwm)      return 2'b10;
    else if (rs != R0 && rs == rdw && rww) return 2'b01;
    else if (rs != R0 && rs == mrd && dn)  return 2'b11;
    else                                   return 2'b00;
  endfunction

  // MC FSM state, latency counter and captured destination
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= 8'd0;
      mc_rd_q <= R0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      mc_rd_q <= mc_rd_nx;
    end
  end

  // MC FSM next state; McOpE outside IDLE is ignored so only one op is ever in flight
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    mc_rd_nx = mc_rd_q;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: begin
        if (hz.McOpE) begin
          state_nx = BUSY;
          cnt_nx   = LAT_M1;
          mc_rd_nx = hz.RdE;
        end
      end
      BUSY: begin
        busy = 1'b1;
        if (cnt == 8'd0) begin
          done     = 1'b1;
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt - 8'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Stall sources; the RAW stall drops on the done cycle because the result is forwarded then
  always_comb begin
    lw     = hz.ResultSrcE[0] && (hz.RdE != R0) &&
             ((hz.Rs1D == hz.RdE) || (hz.Rs2D == hz.RdE));
    sb_raw = busy && !done && (mc_rd_q != R0) &&
             ((hz.Rs1D == mc_rd_q) || (hz.Rs2D == mc_rd_q));
    sb_waw = busy && hz.RegWriteD && (hz.RdD == mc_rd_q) && (mc_rd_q != R0);
    st     = hz.McOpD && busy;
    stall  = lw || sb_raw || sb_waw || st;
  end

  assign hz.StallF    = stall;
  assign hz.StallD    = stall;
  assign hz.FlushD    = hz.PCSrcE;
  assign hz.FlushE    = stall || hz.PCSrcE;
  assign hz.ForwardAE = fwd_sel(hz.Rs1E, hz.RdM, hz.RegWriteM, hz.RdW, hz.RegWriteW, done, mc_rd_q);
  assign hz.ForwardBE = fwd_sel(hz.Rs2E, hz.RdM, hz.RegWriteM, hz.RdW, hz.RegWriteW, done, mc_rd_q);
  assign hz.mc_busy   = busy;
  assign hz.mc_done   = done;
  assign hz.mc_rd     = mc_rd_q;

`ifdef HAZ_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Saturating stall/flush event counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_ONE;
      if (hz.PCSrcE && (flush_cnt != '1))
        flush_cnt <= flush_cnt + CNT_ONE;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_unit_mc.sv
// tb/tb_hazard_unit_mc.sv - scoreboard bench for hazard_unit_mc against a cycle-count reference model
module tb_hazard_unit_mc;

  localparam int AW  = 5;
  localparam int LAT = 4;
  localparam int CW  = 3;
  localparam int N_RANDOM = 800;

  typedef struct {
    logic          rst_n;
    logic [AW-1:0] rs1d, rs2d, rdd, rs1e, rs2e, rde, rdm, rdw;
    logic [1:0]    rsrc;
    logic          rwd, rwm, rww, mcd, mce, pcs;
  } stim_t;

  typedef struct {
    logic          stall, flushd, flushe;
    logic [1:0]    fa, fb;
    logic          busy, done;
    logic [AW-1:0] mcrd;
    int            scnt, fcnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  hazard_unit_mc_if #(.REG_AW(AW)) hif ();

`ifdef HAZ_PERF_CNT_EN
  logic [CW-1:0] stall_cnt, flush_cnt;
`endif

  hazard_unit_mc #(.REG_AW(AW), .MC_LAT(LAT), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hif)
`ifdef HAZ_PERF_CNT_EN
    ,
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  // Reference model: cycles left until the MC result (0 = unit free), its destination, event counts
  int            mc_left;
  logic [AW-1:0] mc_dest;
  int            m_scnt, m_fcnt;
  localparam int CNT_MAX = (1 << CW) - 1;

  exp_t  exp_q[$];
  stim_t stim_q[$];
  int    n_checks = 0;
  int    n_errors = 0;

  function automatic logic [1:0] ref_fwd(input logic [AW-1:0] rs, input stim_t s, input logic dn);
    if (rs != 0 && rs == s.rdm && s.rwm) return 2'b10;
    if (rs != 0 && rs == s.rdw && s.rww) return 2'b01;
    if (rs != 0 && rs == mc_dest && dn)  return 2'b11;
    return 2'b00;
  endfunction

  function automatic exp_t ref_expect(input stim_t s);
    exp_t e;
    logic lw, raw, waw, st;
    e.busy = (mc_left > 0);
    e.done = (mc_left == 1);
    lw  = s.rsrc[0] && s.rde != 0 && (s.rs1d == s.rde || s.rs2d == s.rde);
    raw = e.busy && !e.done && mc_dest != 0 && (s.rs1d == mc_dest || s.rs2d == mc_dest);
    waw = e.busy && s.rwd && s.rdd == mc_dest && mc_dest != 0;
    st  = s.mcd && e.busy;
    e.stall  = lw || raw || waw || st;
    e.flushd = s.pcs;
    e.flushe = e.stall || s.pcs;
    e.fa     = ref_fwd(s.rs1e, s, e.done);
    e.fb     = ref_fwd(s.rs2e, s, e.done);
    e.mcrd   = mc_dest;
    e.scnt   = m_scnt;
    e.fcnt   = m_fcnt;
    return e;
  endfunction

  task automatic ref_step(input stim_t s);
    exp_t e;
    e = ref_expect(s);
    if (!s.rst_n) begin
      mc_left = 0;
      mc_dest = '0;
      m_scnt  = 0;
      m_fcnt  = 0;
    end else begin
      if (e.stall && m_scnt < CNT_MAX) m_scnt++;
      if (s.pcs && m_fcnt < CNT_MAX) m_fcnt++;
      if (mc_left > 0) mc_left--;
      else if (s.mce) begin
        mc_left = LAT;
        mc_dest = s.rde;
      end
    end
  endtask

  task automatic apply(input stim_t s);
    rst_n              = s.rst_n;
    hif.Rs1D           = s.rs1d;
    hif.Rs2D           = s.rs2d;
    hif.RdD            = s.rdd;
    hif.Rs1E           = s.rs1e;
    hif.Rs2E           = s.rs2e;
    hif.RdE            = s.rde;
    hif.RdM            = s.rdm;
    hif.RdW            = s.rdw;
    hif.ResultSrcE     = s.rsrc;
    hif.RegWriteD      = s.rwd;
    hif.RegWriteM      = s.rwm;
    hif.RegWriteW      = s.rww;
    hif.McOpD          = s.mcd;
    hif.McOpE          = s.mce;
    hif.PCSrcE         = s.pcs;
  endtask

  function automatic stim_t quiet();
    stim_t s;
    s.rst_n = 1'b1;
    s.rs1d = '0; s.rs2d = '0; s.rdd = '0; s.rs1e = '0; s.rs2e = '0;
    s.rde = '0; s.rdm = '0; s.rdw = '0; s.rsrc = 2'b00;
    s.rwd = 1'b0; s.rwm = 1'b0; s.rww = 1'b0;
    s.mcd = 1'b0; s.mce = 1'b0; s.pcs = 1'b0;
    return s;
  endfunction

  function automatic logic [AW-1:0] rnd_idx();
    if ($urandom_range(0, 7) == 0) return AW'($urandom_range(0, (1 << AW) - 1));
    return AW'($urandom_range(0, 3));
  endfunction

  function automatic stim_t rnd_stim();
    stim_t s;
    s.rst_n = ($urandom_range(0, 63) != 0);
    s.rs1d = rnd_idx(); s.rs2d = rnd_idx(); s.rdd = rnd_idx();
    s.rs1e = rnd_idx(); s.rs2e = rnd_idx(); s.rde = rnd_idx();
    s.rdm  = rnd_idx(); s.rdw  = rnd_idx();
    s.rsrc = 2'($urandom_range(0, 3));
    s.rwd = 1'($urandom_range(0, 1));
    s.rwm = 1'($urandom_range(0, 1));
    s.rww = 1'($urandom_range(0, 1));
    s.mcd = ($urandom_range(0, 3) == 0);
    s.mce = ($urandom_range(0, 3) == 0);
    s.pcs = ($urandom_range(0, 7) == 0);
    return s;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Directed scenarios followed by random traffic
  task automatic build_stimulus();
    stim_t s;
    s = quiet(); s.rst_n = 1'b0;
    stim_q.push_back(s); stim_q.push_back(s);
    stim_q.push_back(quiet());
    s = quiet(); s.rs1e = 5; s.rdm = 5; s.rdw = 5; s.rwm = 1; s.rww = 1;
    stim_q.push_back(s);
    s = quiet(); s.rs2e = 0; s.rdm = 0; s.rwm = 1;
    stim_q.push_back(s);
    s = quiet(); s.rsrc = 2'b01; s.rde = 7; s.rs2d = 7;
    stim_q.push_back(s);
    s = quiet(); s.rsrc = 2'b01; s.rde = 0; s.rs2d = 0;
    stim_q.push_back(s);
    s = quiet(); s.mce = 1; s.rde = 9;
    stim_q.push_back(s);
    for (int i = 1; i <= LAT; i++) begin
      s = quiet(); s.rs1d = 9; s.mcd = 1; s.rwd = 1; s.rdd = 9;
      s.mce = 1; s.rde = 4;
      if (i == 2) s.pcs = 1;
      if (i == LAT) s.rs1e = 9;
      stim_q.push_back(s);
    end
    s = quiet(); s.mcd = 1; s.rs1d = 9;
    stim_q.push_back(s);
    s = quiet(); s.mce = 1; s.rde = 3;
    stim_q.push_back(s);
    stim_q.push_back(quiet()); stim_q.push_back(quiet());
    s = quiet(); s.rst_n = 1'b0;
    stim_q.push_back(s);
    for (int i = 0; i < LAT + 2; i++) begin
      s = quiet(); s.rs1d = 3; s.rs1e = 3;
      stim_q.push_back(s);
    end
    for (int i = 0; i < N_RANDOM; i++) stim_q.push_back(rnd_stim());
  endtask

  // Monitor: one expected entry per cycle, compared mid-cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("StallF",    32'(hif.StallF),    32'(e.stall));
        check("StallD",    32'(hif.StallD),    32'(e.stall));
        check("FlushD",    32'(hif.FlushD),    32'(e.flushd));
        check("FlushE",    32'(hif.FlushE),    32'(e.flushe));
        check("ForwardAE", 32'(hif.ForwardAE), 32'(e.fa));
        check("ForwardBE", 32'(hif.ForwardBE), 32'(e.fb));
        check("mc_busy",   32'(hif.mc_busy),   32'(e.busy));
        check("mc_done",   32'(hif.mc_done),   32'(e.done));
        check("mc_rd",     32'(hif.mc_rd),     32'(e.mcrd));
`ifdef HAZ_PERF_CNT_EN
        check("stall_cnt", 32'(stall_cnt), 32'(e.scnt));
        check("flush_cnt", 32'(flush_cnt), 32'(e.fcnt));
`endif
      end
    end
  end

  // Driver: advance the model on each edge, then present the next stimulus and its expectation
  initial begin
    stim_t cur;
    mc_left = 0; mc_dest = '0; m_scnt = 0; m_fcnt = 0;
    build_stimulus();
    cur = quiet();
    cur.rst_n = 1'b0;
    apply(cur);
    while (stim_q.size() > 0) begin
      @(posedge clk);
      ref_step(cur);
      #1;
      cur = stim_q.pop_front();
      apply(cur);
      exp_q.push_back(ref_expect(cur));
    end
    @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/hazard_unit_mc.md
HAZARD_UNIT_MC -- requirements
Module: hazard_unit_mc

Interface
REQ-001 Parameter REG_AW, default 5: register-index width; register file has 2**REG_AW entries, index 0 hard-wired zero.
REQ-002 Parameter MC_LAT, default 8, legal 2..255: cycles from multi-cycle (MC) op issue in E to its result-valid cycle.
REQ-003 Parameter CNT_W, default 32: width of performance counters.
REQ-004 clk  input  1  single clock, all state updates on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 Rs1D, Rs2D, RdD  input  REG_AW  decode-stage source and destination indices.
REQ-007 Rs1E, Rs2E, RdE  input  REG_AW  execute-stage source and destination indices.
REQ-008 RdM, RdW  input  REG_AW  memory- and writeback-stage destinations.
REQ-009 ResultSrcE  input  2  bit 0 set means E holds a load.
REQ-010 RegWriteD, RegWriteM, RegWriteW  input  1  register-write enables per stage.
REQ-011 McOpD, McOpE  input  1  D/E holds an MC op (divide class).
REQ-012 PCSrcE  input  1  taken branch/jump resolved in E.
REQ-013 StallF, StallD, FlushD, FlushE  output  1  pipeline controls.
REQ-014 ForwardAE, ForwardBE  output  2  00 regfile, 01 W result, 10 M result, 11 MC result.
REQ-015 mc_busy  output  1  MC unit occupied.
REQ-016 mc_done  output  1  one-cycle pulse, MC result valid this cycle.
REQ-017 mc_rd  output  REG_AW  destination of in-flight MC op.

Function
REQ-018 ForwardAE: 10 if Rs1E==RdM, RegWriteM, Rs1E!=0; else 01 if Rs1E==RdW, RegWriteW, Rs1E!=0; else 11 if mc_done, Rs1E==mc_rd, Rs1E!=0; else 00. ForwardBE identical using Rs2E.
REQ-019 Load-use stall lw = ResultSrcE[0], RdE!=0, and (Rs1D==RdE or Rs2D==RdE).
REQ-020 MC FSM states IDLE, BUSY; IDLE->BUSY when McOpE=1, loading counter with MC_LAT-1 and capturing mc_rd<=RdE.
REQ-021 BUSY: counter decrements each cycle; mc_done=1 in the cycle counter==0; next state IDLE.
REQ-022 mc_busy=1 in BUSY, including the mc_done cycle.
REQ-023 RAW scoreboard stall sb_raw = mc_busy, !mc_done, mc_rd!=0, and (Rs1D==mc_rd or Rs2D==mc_rd).
REQ-024 WAW stall sb_waw = mc_busy, RegWriteD, RdD==mc_rd, mc_rd!=0; held through the mc_done cycle.
REQ-025 Structural stall st = McOpD and mc_busy; released the cycle after mc_done.
REQ-026 stall = lw or sb_raw or sb_waw or st; StallF=StallD=stall.
REQ-027 FlushD = PCSrcE; FlushE = stall or PCSrcE.
REQ-028 Only one MC op in flight; McOpE while BUSY cannot occur by REQ-025, and is ignored if it does.
REQ-029 PCSrcE does not cancel an MC op already in BUSY (it is older than the branch).
REQ-030 All pipeline-control and forward outputs are combinational from inputs and current state.

Reset
REQ-031 rst_n=0 at a rising edge: state IDLE, counter 0, mc_rd 0; mc_busy=0, mc_done=0, no scoreboard stalls from the next cycle.
REQ-032 Reset mid-BUSY abandons the MC op; no mc_done pulse is produced for it.
REQ-033 Performance counters clear to 0 on reset.

Configuration
REQ-034 Macro HAZ_PERF_CNT_EN defined: adds outputs stall_cnt and flush_cnt (CNT_W each); stall_cnt +1 per cycle with stall=1; flush_cnt +1 per cycle with PCSrcE=1; both saturate at all-ones.
REQ-035 Macro undefined: counters and ports absent; all other behaviour identical.

Verification
REQ-036 Rs1E=RdM=RdW=5, RegWriteM=RegWriteW=1 -> ForwardAE=10; Rs2E=0 with RdM=0, RegWriteM=1 -> ForwardBE=00.
REQ-037 Load in E, RdE=7, Rs2D=7 -> StallF=StallD=FlushE=1 for one cycle; RdE=0 instead -> no stall.
REQ-038 MC_LAT=4, McOpE, RdE=9 -> mc_busy for 4 cycles, mc_done on 4th; Rs1D=9 stalls cycles 1-3; on done cycle, Rs1E=9 gives ForwardAE=11.
REQ-039 Second McOpD during BUSY -> stalled until the cycle after mc_done, then issues; RegWriteD with RdD=mc_rd stalls through done cycle.
REQ-040 PCSrcE=1 during BUSY -> FlushD=FlushE=1, MC op still completes; rst_n=0 mid-BUSY -> IDLE, no mc_done.
REQ-041 With HAZ_PERF_CNT_EN, 3 stall cycles and 2 branches -> stall_cnt=3, flush_cnt=2; CNT_W=2 held stalled 5 cycles -> stall_cnt=3.
